// File: rtl/truth_table_probe_pkg.sv
// Shared types and helpers for the truth-table probe: sweep states, table
// geometry and the row-to-ID bit mapping used by the gate-naming convention.
package truth_table_pkg;

    localparam int NUM_ROWS = 8;
    localparam int ID_W     = 8;
    localparam int ROW_W    = $clog2(NUM_ROWS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } probe_state_e;

    // Row 000 lands in the MSB so the ID reads left-to-right like the table.
    function automatic logic [ROW_W-1:0] row_to_bit(input logic [ROW_W-1:0] r);
        return ROW_W'(NUM_ROWS - 1) - r;
    endfunction

endpackage

// File: rtl/truth_table_probe_if.sv
// Handshake and probe bus between the characterizer and whoever drives it;
// dut_out comes back from the gate under test and may be asynchronous.
interface truth_table_probe_if;

    logic       start;
    logic       abort;
    logic [7:0] expected_id;
    logic [2:0] stim;
    logic       dut_out;
    logic       busy;
    logic       done;
    logic       id_valid;
    logic [7:0] truth_id;
    logic       match;

    modport master (
        output start, abort, expected_id, dut_out,
        input  stim, busy, done, id_valid, truth_id, match
    );

    modport slave (
        input  start, abort, expected_id, dut_out,
        output stim, busy, done, id_valid, truth_id, match
    );

endinterface

// File: rtl/truth_table_probe_sync.sv
// Multi-flop synchronizer for the gate output, which has no timing
// relationship to clk.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign dout = chain[STAGES-1];

endmodule

// File: rtl/truth_table_probe.sv
// Sweeps all eight input rows through an external 3-input gate, samples its
// output after a settle window and assembles the 0xNN truth-table ID.
module truth_table_probe
    import truth_table_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    truth_table_probe_if.slave  bus
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

    generate
        if (SYNC_STAGES < 1) begin : g_bad_sync
            $error("truth_table_probe: SYNC_STAGES must be at least 1");
        end
        if (SETTLE_CYCLES < SYNC_STAGES + 1) begin : g_bad_settle
            $error("truth_table_probe: SETTLE_CYCLES must be at least SYNC_STAGES+1");
        end
    endgenerate

    logic [1:0]       rst_pipe;
    logic             rst_int_n;
    logic             sampled;

    probe_state_e     state;
    logic [ROW_W-1:0] row;
    logic [CNT_W-1:0] cnt;
    logic [ID_W-1:0]  exp_q;
    logic [ID_W-1:0]  id_q;
    logic [2:0]       stim_q;
    logic             busy_q;
    logic             done_q;
    logic             valid_q;
    logic             match_q;

    // Reset asserts immediately but releases on a clock edge so the FSM
    // never sees a runt deassertion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_int_n = rst_pipe[1];

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (bus.dut_out),
        .dout  (sampled)
    );

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state   <= IDLE;
            row     <= '0;
            cnt     <= '0;
            exp_q   <= '0;
            id_q    <= '0;
            stim_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            match_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        exp_q   <= bus.expected_id;
                        id_q    <= '0;
                        valid_q <= 1'b0;
                        match_q <= 1'b0;
                        row     <= '0;
                        cnt     <= '0;
                        stim_q  <= '0;
                        busy_q  <= 1'b1;
                        state   <= SETTLE;
                    end
                end

                SETTLE: begin
                    if (bus.abort) begin
                        stim_q <= '0;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else if (cnt == LAST_CNT) begin
                        id_q[row_to_bit(row)] <= sampled;
                        cnt <= '0;
                        if (row == LAST_ROW) begin
                            stim_q <= '0;
                            busy_q <= 1'b0;
                            state  <= DONE;
                        end else begin
                            row    <= row + ROW_W'(1);
                            stim_q <= row + ROW_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                DONE: begin
                    // The last row is already in id_q here, so the compare is final.
                    if (!bus.abort) begin
                        done_q  <= 1'b1;
                        valid_q <= 1'b1;
                        match_q <= (id_q == exp_q);
                    end
                    state <= IDLE;
                end

                default: begin
                    stim_q <= '0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.stim     = stim_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.id_valid = valid_q;
    assign bus.truth_id = id_q;
    assign bus.match    = match_q;

endmodule

// File: tb/tb_truth_table_probe.sv
// Randomized self-checking bench: behavioural gate models feed two probes
// (S=4 and S=3) and a row-table reference model predicts each ID.
module tb_truth_table_probe;

    localparam int S = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    truth_table_probe_if bus();
    truth_table_probe_if bus3();

    logic [7:0] rows_out = 8'h00;
    logic       delay_mode = 1'b0;
    logic       dly1 = 1'b0, dly2 = 1'b0;
    logic       dly3_1 = 1'b0, dly3_2 = 1'b0;

    int tests = 0;
    int fails = 0;

    truth_table_probe #(.SETTLE_CYCLES(S), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    truth_table_probe #(.SETTLE_CYCLES(3), .SYNC_STAGES(2)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3.slave)
    );

    // Gate output as a slow path: two falling-edge stages, just under two cycles.
    always @(negedge clk) begin
        dly1   <= rows_out[bus.stim];
        dly2   <= dly1;
        dly3_1 <= rows_out[bus3.stim];
        dly3_2 <= dly3_1;
    end

    assign bus.dut_out  = delay_mode ? dly2 : rows_out[bus.stim];
    assign bus3.dut_out = dly3_2;

    // rows bit r is the gate output for input row r; a late gate is seen one row behind.
    function automatic logic [7:0] model_id(input logic [7:0] rows, input bit lagging);
        int id = 0;
        for (int r = 0; r < 8; r++) begin
            int src = (lagging && r > 0) ? r - 1 : r;
            id += int'(rows[src]) * (1 << (7 - r));
        end
        return 8'(id);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] exp_id);
        bus.expected_id = exp_id;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic checkIdleReset(input string tag);
        checkOutput({tag, "_stim"},  32'(bus.stim), 32'd0);
        checkOutput({tag, "_busy"},  32'(bus.busy), 32'd0);
        checkOutput({tag, "_done"},  32'(bus.done), 32'd0);
        checkOutput({tag, "_valid"}, 32'(bus.id_valid), 32'd0);
        checkOutput({tag, "_id"},    32'(bus.truth_id), 32'd0);
        checkOutput({tag, "_match"}, 32'(bus.match), 32'd0);
    endtask

    task automatic runSweep(input logic [7:0] rows, input logic [7:0] exp_id,
                            input bit delayed, input bit poke_start);
        logic [7:0] want;
        int extra;
        want = model_id(rows, 1'b0);
        rows_out = rows;
        delay_mode = delayed;
        repeat (3) tick();
        applyStimulus(exp_id);
        for (int k = 1; k <= 8 * S; k++) begin
            checkOutput("sweep_busy", 32'(bus.busy), 32'd1);
            checkOutput("sweep_stim", 32'(bus.stim), 32'((k - 1) / S));
            checkOutput("sweep_done_early", 32'(bus.done), 32'd0);
            if (poke_start) bus.start = (k == 10);
            tick();
        end
        bus.start = 1'b0;
        checkOutput("tail_busy", 32'(bus.busy), 32'd0);
        checkOutput("tail_stim", 32'(bus.stim), 32'd0);
        checkOutput("tail_done", 32'(bus.done), 32'd0);
        tick();
        checkOutput("done_pulse", 32'(bus.done), 32'd1);
        checkOutput("id_valid", 32'(bus.id_valid), 32'd1);
        checkOutput("truth_id", 32'(bus.truth_id), 32'(want));
        checkOutput("match", 32'(bus.match), 32'(want == exp_id));
        tick();
        checkOutput("done_single", 32'(bus.done), 32'd0);
        checkOutput("id_hold", 32'(bus.truth_id), 32'(want));
        checkOutput("valid_hold", 32'(bus.id_valid), 32'd1);
        if (poke_start) begin
            extra = 0;
            repeat (8 * S + 4) begin
                tick();
                extra += int'(bus.done) + int'(bus.busy);
            end
            checkOutput("start_ignored", 32'(extra), 32'd0);
        end
    endtask

    initial begin
        int activity;
        int waited;
        logic [7:0] r_rows, r_exp;

        rst_n = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.expected_id = 8'h00;
        bus3.start = 1'b0; bus3.abort = 1'b0; bus3.expected_id = 8'h00;
        repeat (2) tick();
        checkIdleReset("reset");
        rst_n = 1'b1;
        repeat (4) tick();

        // The 0xC5 gate, also with a slow output, then constant gates.
        runSweep(8'hA3, 8'hC5, 1'b0, 1'b0);
        runSweep(8'hA3, 8'hC5, 1'b1, 1'b0);
        runSweep(8'h00, 8'hC5, 1'b0, 1'b0);
        runSweep(8'hFF, 8'hC5, 1'b0, 1'b0);

        // Randomized gates and references, about half of them matching.
        for (int n = 0; n < 6; n++) begin
            r_rows = 8'($urandom);
            r_exp  = ($urandom_range(1) == 1) ? model_id(r_rows, 1'b0) : 8'($urandom);
            runSweep(r_rows, r_exp, 1'($urandom_range(1)), 1'b0);
        end

        runSweep(8'($urandom), 8'h5A, 1'b0, 1'b1);

        // Abort while row 3 is on the stimulus.
        applyStimulus(8'hC5);
        repeat (3 * S) tick();
        checkOutput("abort_row", 32'(bus.stim), 32'd3);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checkOutput("abort_stim", 32'(bus.stim), 32'd0);
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        activity = 0;
        repeat (8 * S) begin
            tick();
            activity += int'(bus.done) + int'(bus.busy) + int'(bus.id_valid);
        end
        checkOutput("abort_quiet", 32'(activity), 32'd0);
        runSweep(8'hA3, 8'hC5, 1'b0, 1'b0);

        // Start together with abort in IDLE is dropped.
        bus.start = 1'b1; bus.abort = 1'b1;
        tick();
        bus.start = 1'b0; bus.abort = 1'b0;
        activity = 0;
        repeat (4) begin
            activity += int'(bus.busy);
            tick();
        end
        checkOutput("start_abort_busy", 32'(activity), 32'd0);
        checkOutput("start_abort_valid", 32'(bus.id_valid), 32'd1);

        // Reset asserted while row 5 is being driven.
        applyStimulus(8'hC5);
        repeat (5 * S + 1) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkIdleReset("midreset");
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        r_rows = 8'($urandom);
        runSweep(r_rows, model_id(r_rows, 1'b0), 1'b1, 1'b0);

        // A three-cycle settle is too short for the slow gate: one row of lag.
        rows_out = 8'hA3;
        repeat (3) tick();
        bus3.expected_id = 8'hC5;
        bus3.start = 1'b1;
        tick();
        bus3.start = 1'b0;
        waited = 0;
        while (!bus3.done && waited < 60) begin
            tick();
            waited++;
        end
        checkOutput("short_settle_done", 32'(bus3.done), 32'd1);
        checkOutput("short_settle_id", 32'(bus3.truth_id), 32'(model_id(8'hA3, 1'b1)));
        checkOutput("short_settle_match", 32'(bus3.match), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/truth_table_probe.md
# truth_table_probe

Sequential characterizer for 3-input logic blocks. It drives all eight input combinations into an external combinational function block and samples that block's output after a settle window. It then assembles the 8-bit truth-table ID in the team's `0xNN` gate-naming convention. It sits beside a gate under test in bring-up and regression builds, comparing the measured ID against an expected one.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 4: cycles each input combination is held before its sample. Must be ≥ `SYNC_STAGES`+1; elaboration error otherwise.
- `SYNC_STAGES`, default 2: synchronizer depth on `dut_out`. Must be ≥ 1.

Ports (clock and reset first):
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request a sweep; honored only in IDLE.
- `abort`, input, 1: synchronous cancel of a sweep in progress.
- `expected_id`, input, 8: reference ID for comparison; sampled at `start`.
- `stim`, output, 3: `{in1,in2,in3}` driven to the gate under test.
- `dut_out`, input, 1: gate output; may be asynchronous to `clk`.
- `busy`, output, 1: sweep in progress.
- `done`, output, 1: one-cycle pulse on sweep completion.
- `id_valid`, output, 1: `truth_id` holds a complete result.
- `truth_id`, output, 8: measured ID.
- `match`, output, 1: `truth_id == expected_id` latched; qualified by `id_valid`.

## Operation
- **Bit mapping**: row r (where r = `{in1,in2,in3}`, 0..7) maps to `truth_id[7-r]`. Row 000 is the MSB, so a gate with outputs 1,1,0,0,0,1,0,1 for rows 000..111 yields 0xC5.
- **States**: IDLE, SETTLE, DONE.
- **IDLE**:
  - `stim`=000, `busy`=0.
  - On `start`=1 with `abort`=0: latch `expected_id`; clear `id_valid`, `match` and `truth_id`; set row=0 and settle count=0; go to SETTLE.
- **SETTLE**:
  - `stim`=row and `busy`=1.
  - The count increments each cycle.
  - On the edge where count == `SETTLE_CYCLES`-1, capture the synchronized `dut_out` into bit 7-row.
  - If row<7: row increments and count resets to 0.
  - If row==7: go to DONE.
- **DONE** (one cycle):
  - `done`=1, `id_valid`=1, `match` updated, `busy`=0, `stim`=000.
  - Return to IDLE on the next edge.
- **`start` outside IDLE**: ignored; no queuing.
- **`abort` in SETTLE or DONE**: next edge goes to IDLE with `stim`=000. No `done` pulse; `id_valid` stays 0.
- **`abort` with `start` in IDLE**: `abort` wins and the start is dropped.
- **`truth_id` and `id_valid` hold** until the next accepted `start`.
- **Row counter** is 3 bits; wrap from 7 never occurs because the exit at row 7 happens first.

## Timing
- **Reset values**: `stim`=000, `busy`=0, `done`=0, `id_valid`=0, `truth_id`=0x00, `match`=0, state IDLE, synchronizer flops 0.
- **Reset mid-sweep**: all outputs take reset values immediately (asynchronous assertion); deassertion is synchronized by the top level.
- **Start and `busy`**: the `start` accept edge is T; `busy` is high from T+1.
- **Row windows**: row r is driven during cycles T+1+r·S through T+(r+1)·S, where S=`SETTLE_CYCLES`.
- **Sampling**: row r is sampled at edge T+(r+1)·S using the synchronizer output, i.e. `dut_out` as seen `SYNC_STAGES` cycles earlier.
- **Completion**: `done`, `id_valid` and `match` are high in the cycle after edge T+8S+1. Total latency from `start` to `done` is 8S+1 cycles.
- **Back-to-back**: the earliest next `start` is accepted in the cycle `done` is deasserted (IDLE).

## Structure
- Package `truth_table_pkg`:
  - state enum (IDLE, SETTLE, DONE);
  - `NUM_ROWS`=8;
  - `ID_W`=8;
  - function `row_to_bit(r)` returning 7-r.
- One natural sub-module: `bit_synchronizer` (`SYNC_STAGES`-deep flop chain on `dut_out`, reset via `rst_n`).
- Counters sized to `$clog2(SETTLE_CYCLES)` bits and 3 bits for row.

## Test plan
- **0xC5 model, S=4**: `start` with `expected_id`=0xC5 → `done` 33 cycles later, `truth_id`=0xC5, `match`=1. Stim rows 000..111 are observed in order, each held 4 cycles.
- **Constant-0 and constant-1 models**: `truth_id`=0x00, then 0xFF. With `expected_id`=0xC5, `match`=0 both times.
- **Model adding 2 cycles of output delay, S=4**: still 0xC5. With S=3 and `SYNC_STAGES`=2, the delayed model yields a shifted (wrong) ID, demonstrating the settle requirement.
- **Abort while row=3**: `stim` is 000 next cycle, `busy`=0, no `done`, `id_valid`=0. A subsequent `start` completes normally.
- **`rst_n` low at row 5**: all outputs are at reset values in the same cycle. After release and `start`, a correct ID is produced.
- **`start` pulsed while `busy`**: ignored; exactly one `done`. `start` with `abort` in IDLE: no sweep begins.
